// File: rtl/ctrl_trace_encoder.sv
// Trace encoder: re-encodes each retired control bundle into its MIPS opcode,
// flags bundles the decoder cannot produce, and queues {opcode, illegal, pc} records.
module ctrl_trace_encoder #(
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic                     RegDst,
    input  logic                     Jump,
    input  logic                     beq,
    input  logic                     bne,
    input  logic                     MemRead,
    input  logic                     MemtoReg,
    input  logic                     MemWrite,
    input  logic                     ALUSrc,
    input  logic                     RegWrite,
    input  logic [1:0]               aluop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5:0]               out_opcode,
    output logic [31:0]              out_pc,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNTW-1:0]          drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam int RW = 39;

    logic [10:0]   key;
    logic [5:0]    enc_opcode;
    logic          enc_illegal;

    logic          s1_valid;
    logic [5:0]    s1_opcode;
    logic          s1_illegal;
    logic [31:0]   s1_pc;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [RW-1:0] head;

    assign key = {RegDst, Jump, beq, bne, MemRead, MemtoReg, MemWrite,
                  ALUSrc, RegWrite, aluop};

    // Exact match only: any bundle outside the decoder's eight outputs is illegal.
    always_comb begin
        enc_opcode  = 6'b111111;
        enc_illegal = 1'b0;
        case (key)
            11'b00001101100: enc_opcode = 6'b100011;
            11'b00000011000: enc_opcode = 6'b101011;
            11'b10000000110: enc_opcode = 6'b000000;
            11'b00000001100: enc_opcode = 6'b001000;
            11'b00000001111: enc_opcode = 6'b001100;
            11'b10100000001: enc_opcode = 6'b000100;
            11'b10010000001: enc_opcode = 6'b000101;
            11'b11000000010: enc_opcode = 6'b000010;
            default:         enc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_opcode  <= 6'b0;
            s1_illegal <= 1'b0;
            s1_pc      <= 32'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_opcode  <= enc_opcode;
                s1_illegal <= enc_illegal;
                s1_pc      <= in_pc;
            end
        end
    end

    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s1_illegal, s1_opcode, s1_pc};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNTW{1'b1}}) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end
        end
    end

    assign head        = mem[rd_ptr];
    assign out_illegal = out_valid ? head[RW-1]     : 1'b0;
    assign out_opcode  = out_valid ? head[RW-2:32]  : 6'b0;
    assign out_pc      = out_valid ? head[31:0]     : 32'b0;

endmodule

// File: doc/ctrl_trace_encoder.md
# ctrl_trace_encoder

Inverse of the single-cycle control decoder. Each retired instruction's control-signal bundle and PC are sampled. The bundle is re-encoded back into its 6-bit MIPS opcode, and the record is buffered in a show-ahead FIFO drained over a valid/ready handshake. The block sits beside the datapath as a debug/trace port and checks decoder consistency: any bundle the decoder cannot produce is flagged illegal.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- CNTW, 8, width of saturating drop counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  one instruction retires this cycle; sample bundle and PC
- in_pc  input  32  PC of retiring instruction
- RegDst, Jump, beq, bne, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  input  1 each  control bundle
- aluop  input  2  ALU op class
- out_valid  output  1  head record present
- out_ready  input  1  consumer accepts head record
- out_opcode  output  6  re-encoded opcode
- out_pc  output  32  PC of head record
- out_illegal  output  1  bundle matched no legal pattern
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky; a record was dropped
- drop_cnt  output  CNTW  dropped records, saturating

## Operation
- Bundle key B = {RegDst,Jump,beq,bne,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite,aluop[1:0]}, 11 bits. Exact-match encode:
  - 00001101100 → 100011 (lw)
  - 00000011000 → 101011 (sw)
  - 10000000110 → 000000 (R)
  - 00000001100 → 001000 (addi)
  - 00000001111 → 001100 (andi)
  - 10100000001 → 000100 (beq)
  - 10010000001 → 000101 (bne)
  - 11000000010 → 000010 (j)
  - any other B, including all-zero → opcode 111111, illegal=1
- Stage S1: on in_valid, register {encoded opcode, illegal, in_pc} and set s1_valid. Otherwise clear s1_valid.
- Stage S2 (FIFO push): when s1_valid is set, push if not full, or if full with a pop in the same cycle.
- Drop: if s1_valid is set and the FIFO is full with no pop, the record is discarded, overflow is set, and drop_cnt increments, saturating at 2^CNTW−1.
- Pop when out_valid && out_ready. out_valid = (count≠0).
- Push+pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- out_opcode, out_pc and out_illegal present mem[rd_ptr] when out_valid=1 and are forced to 0 when out_valid=0.
- overflow and drop_cnt clear only on rst.

## Timing
- Reset (rst high at a rising edge): s1_valid=0, pointers=0, count=0, overflow=0, drop_cnt=0. Consequently out_valid=0, out_opcode=0, out_pc=0, out_illegal=0 from the following cycle.
- Reset mid-operation discards the FIFO contents and any S1 record. An in_valid sampled in the same cycle as rst is ignored.
- Latency: in_valid in cycle N → S1 holds the record in N+1 → record is in the FIFO and out_valid=1 in N+2 if the FIFO was empty.
- Throughput: one record per cycle in and out. Sustained in_valid=1 with out_ready=1 never drops.
- The handshake is purely combinational on out_ready. out_valid never depends on out_ready; there are no comb paths from in_* to out_*.
- Full boundary: count=DEPTH and no pop → drop. count=DEPTH with a pop → accept, count stays DEPTH.
- Empty boundary: a push into an empty FIFO is visible on out_* the next cycle, not the same cycle.

## Test plan
- Reset, then lw bundle 00001101100 with in_pc=0x00400000 in cycle N → cycle N+2: out_valid=1, out_opcode=100011, out_pc=0x00400000, out_illegal=0.
- All 8 legal bundles back-to-back, PCs 0x00400000+4k, out_ready=1 → outputs one per cycle in order 100011,101011,000000,001000,001100,000100,000101,000010, count≤2, no drops.
- Bundles 00000000000 and 11111111111 → out_opcode=111111, out_illegal=1 for both.
- DEPTH=8, out_ready=0, 10 consecutive in_valid → count=8, overflow=1, drop_cnt=2. Then out_ready=1 → first 8 PCs drain in order, count reaches 0, overflow remains 1.
- FIFO full, s1_valid=1 and out_ready=1 in the same cycle → count stays 8, drop_cnt unchanged, new record appears last.
- count=5 with s1_valid=1, assert rst for one cycle → next cycle out_valid=0, count=0, overflow=0, drop_cnt=0. The S1 record never appears.
